// File: rtl/commit_trace_if.sv
// Commit/golden record handshake between a trace source and the commit checker.
// The checker sits on the slave side and drives exp_ready back.
interface commit_trace_if;
  logic        commit_valid;
  logic [70:0] commit_rec;
  logic        exp_valid;
  logic [70:0] exp_rec;
  logic        exp_ready;

  modport master (
    output commit_valid, commit_rec, exp_valid, exp_rec,
    input  exp_ready
  );

  modport slave (
    input  commit_valid, commit_rec, exp_valid, exp_rec,
    output exp_ready
  );
endinterface

// File: rtl/commit_trace_checker.sv
// Lockstep commit checker: buffers retired DUT records and compares them in order
// against a golden stream, flagging mismatch, overflow or timeout as sticky errors.
module commit_trace_checker #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  commit_trace_if.slave       bus,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic [5:0]          mismatch_fields,
  output logic [15:0]         inst_count,
  output logic [31:0]         cycle_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef struct packed {
    logic [15:0] pc;
    logic        regwrite;
    logic [2:0]  wreg;
    logic [15:0] wdata;
    logic        memread;
    logic        memwrite;
    logic [15:0] addr;
    logic [15:0] mdata;
    logic        halt;
  } rec_t;

  typedef enum logic [1:0] {ST_RUN, ST_DONE, ST_ERROR} state_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_MISMATCH, ERR_OVERFLOW, ERR_TIMEOUT} err_e;

  state_e          state_q;
  err_e            err_code_q;
  logic            done_q, error_q;
  logic [5:0]      mismatch_q;
  logic [15:0]     inst_q;
  logic [31:0]     cycle_q;
  logic [TW-1:0]   idle_q;

  rec_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;

  logic            run, push, pop, push_ok, overflow, timeout_hit, cmp_mismatch;
  rec_t            head, expd;
  logic [5:0]      diff;

  // NOTE: every variable driven here gets a default first, so no latch can be inferred.
  always_comb begin
    run           = (state_q == ST_RUN);
    push          = run && bus.commit_valid;
    bus.exp_ready = run && (count_q != '0);
    pop           = bus.exp_ready && bus.exp_valid;
    push_ok       = push && ((count_q != FULL_CNT) || pop);
    overflow      = push && !pop && (count_q == FULL_CNT);
    timeout_hit   = run && !push && (idle_q == TO_LAST);

    head = rec_t'(mem_q[rd_ptr_q]);
    expd = rec_t'(bus.exp_rec);

    // Operand fields only count when the golden kind says they carry meaning.
    diff    = '0;
    diff[0] = (head.pc != expd.pc);
    diff[1] = ({head.regwrite, head.memread, head.memwrite, head.halt} !=
               {expd.regwrite, expd.memread, expd.memwrite, expd.halt});
    diff[2] = expd.regwrite && (head.wreg  != expd.wreg);
    diff[3] = expd.regwrite && (head.wdata != expd.wdata);
    diff[4] = (expd.memread || expd.memwrite) && (head.addr != expd.addr);
    diff[5] = expd.memwrite && (head.mdata != expd.mdata);

    cmp_mismatch = pop && (diff != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      err_code_q <= ERR_NONE;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      mismatch_q <= '0;
      inst_q     <= '0;
    end else if (state_q == ST_RUN) begin
      if (cmp_mismatch) begin
        state_q    <= ST_ERROR;
        err_code_q <= ERR_MISMATCH;
        error_q    <= 1'b1;
        mismatch_q <= diff;
      end else begin
        if (pop) inst_q <= inst_q + 16'd1;
        if (pop && expd.halt) begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end else if (overflow) begin
          state_q    <= ST_ERROR;
          err_code_q <= ERR_OVERFLOW;
          error_q    <= 1'b1;
        end else if (timeout_hit) begin
          state_q    <= ST_ERROR;
          err_code_q <= ERR_TIMEOUT;
          error_q    <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rec_t'(bus.commit_rec);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q  <= '0;
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (push)     idle_q <= '0;
      else if (run) idle_q <= idle_q + 1'b1;
    end
  end

  assign done            = done_q;
  assign error           = error_q;
  assign err_code        = err_code_q;
  assign mismatch_fields = mismatch_q;
  assign inst_count      = inst_q;
  assign cycle_count     = cycle_q;

endmodule

// File: doc/commit_trace_checker.md
COMMIT_TRACE_CHECKER -- requirements
Module: commit_trace_checker

Interface
REQ-001 Parameter DEPTH, default 4: commit buffer entries (power of two, at least 2).
REQ-002 Parameter TIMEOUT, default 1024: maximum cycles in RUN with no commit push before a timeout error.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 commit_valid  input  1  DUT retired one instruction this cycle.
REQ-006 commit_rec  input  71  DUT commit record.
REQ-007 exp_valid  input  1  golden record available on exp_rec.
REQ-008 exp_rec  input  71  golden record, same layout as commit_rec.
REQ-009 exp_ready  output  1  checker consumes exp_rec this cycle.
REQ-010 done  output  1  halt record matched; checking complete.
REQ-011 error  output  1  checking failed; sticky until reset.
REQ-012 err_code  output  2  failure cause: 0 none, 1 mismatch, 2 overflow, 3 timeout.
REQ-013 mismatch_fields  output  6  differing fields: [0] pc, [1] kind, [2] wreg, [3] wdata, [4] addr, [5] mdata.
REQ-014 inst_count  output  16  records compared and matched.
REQ-015 cycle_count  output  32  cycles since reset release.
REQ-016 Record layout (MSB to LSB):
- pc[70:55], regwrite[54], wreg[53:51], wdata[50:35]
- memread[34], memwrite[33], addr[32:17], mdata[16:1], halt[0]

Function
REQ-017 States SHALL be RUN, DONE and ERROR; DONE and ERROR are terminal until reset.
REQ-018 In RUN, commit_valid SHALL push commit_rec into a DEPTH-entry FIFO.
REQ-019 In DONE or ERROR, commit_valid SHALL be ignored.
REQ-020 exp_ready SHALL be 1 only in RUN with the FIFO non-empty, combinationally.
REQ-021 A compare SHALL occur when exp_valid and exp_ready are both 1; that edge pops the FIFO head.
REQ-022 Compared fields:
- pc and kind (regwrite, memread, memwrite, halt flags) always.
- wreg and wdata only if expected regwrite=1.
- addr only if expected memread or memwrite=1.
- mdata only if expected memwrite=1.
REQ-023 On a matching compare, inst_count SHALL increment (wrapping at 16 bits).
REQ-024 A matching compare with halt=1 SHALL enter DONE; done=1 from the following cycle.
REQ-025 On a mismatch, the checker SHALL:
- enter ERROR with err_code=1;
- latch mismatch_fields;
- leave inst_count unchanged;
- raise error=1 the cycle after the compare edge.
REQ-026 A push to a full FIFO with no pop on the same edge SHALL enter ERROR with err_code=2; the record is dropped.
REQ-027 A push and pop on the same edge with the FIFO full SHALL be legal; occupancy stays DEPTH.
REQ-028 Push and pop together at any occupancy SHALL keep occupancy unchanged and preserve FIFO order.
REQ-029 A timeout counter SHALL clear on every push and increment each RUN cycle without a push.
REQ-030 When the timeout counter reaches TIMEOUT, the checker SHALL enter ERROR with err_code=3.
REQ-031 If overflow and mismatch occur on the same edge, err_code SHALL be 1 (mismatch has priority).
REQ-032 cycle_count SHALL increment every cycle in every state and wrap at 32 bits.
REQ-033 The checker SHALL not modify mismatch_fields or err_code after leaving RUN.

Reset
REQ-034 While rst=0, the checker SHALL hold:
- state RUN, FIFO empty, timeout counter 0;
- exp_ready=0, done=0, error=0, err_code=0, mismatch_fields=0, inst_count=0, cycle_count=0.
REQ-035 Reset assertion mid-compare or mid-push SHALL discard all buffered records immediately; nothing is committed after release.
REQ-036 First push SHALL be accepted on the first rising edge after rst returns to 1.

Verification
REQ-037 Scenario: 3 commits then a halt, each matching (pc 0x0000, 0x0002, 0x0004, 0x0006; halt on the last) -> done=1, inst_count=4, error=0.
REQ-038 Scenario: regwrite commit wreg=3, wdata=0x1234; expected wdata=0x1235 -> error=1, err_code=1, mismatch_fields=6'b001000, inst_count unchanged.
REQ-039 Scenario: store commit with regwrite=0 and differing wreg; addr and mdata equal -> match, inst_count increments.
REQ-040 Scenario: exp_valid held 0 for DEPTH+1 consecutive commits -> err_code=2 on the (DEPTH+1)th push.
REQ-041 Scenario: FIFO full, simultaneous push and matching pop -> no error, occupancy stays DEPTH.
REQ-042 Scenario: no commits for TIMEOUT cycles after reset release -> err_code=3; rst pulse low then clears all outputs to 0.
